// File: rtl/mult_pkg.sv
// ============================================================================
// Module : mult_pkg
// Brief  : Shared types and helpers for the shift-and-add multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int c_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of the low w bits of v, treated as two's complement when en=1.
    // The most negative value maps to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [c_MAX_W-1:0] abs_w(
        input logic [c_MAX_W-1:0] v,
        input int unsigned        w,
        input logic               en
    );
        logic [c_MAX_W-1:0] mask;
        logic [4:0]         msb;
        mask = (w >= c_MAX_W) ? '1 : ((c_MAX_W'(1) << w) - c_MAX_W'(1));
        msb  = 5'(w - 1);
        if (en && v[msb]) begin
            abs_w = (~v + c_MAX_W'(1)) & mask;
        end else begin
            abs_w = v & mask;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_shift_add.sv
// ============================================================================
// Module : seq_mult_shift_add
// Brief  : Iterative shift-and-add multiplier, one multiplier bit per cycle,
//          signed/unsigned per operation, valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_mult_shift_add
    import mult_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int               c_PW   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [c_PW-1:0]   r_acc;
    logic [c_PW-1:0]   r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg;
    logic [c_PW-1:0]   r_product;
    logic              r_out_valid;

    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic [c_PW-1:0]   w_sum;
    logic [c_PW-1:0]   w_prod_final;

    assign w_a_mag      = WIDTH'(abs_w(c_MAX_W'(a), WIDTH, is_signed));
    assign w_b_mag      = WIDTH'(abs_w(c_MAX_W'(b), WIDTH, is_signed));
    assign w_sum        = r_acc + (r_mplier[0] ? r_mcand : '0);
    // Sign is reapplied to the full-width sum on the final step only.
    assign w_prod_final = r_neg ? (~w_sum + c_PW'(1)) : w_sum;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign product   = r_product;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_next_state = BUSY;
            BUSY:    if (r_cnt == c_LAST) w_next_state = DONE;
            DONE:    if (out_ready)       w_next_state = IDLE;
            default:                      w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                BUSY: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_product   <= w_prod_final;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
